eret_unit: RTL and testbench

//  Exception-return sequencer for the refcpu CP0 path; counterpart of the exception-entry logic.

---
 rtl/eret_unit.sv | 161 ++++++++++++++++
 tb/tb_eret_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eret_unit.sv
// rtl/eret_unit.sv - exception-return sequencer for the CP0 path
//
// Purpose: accepts an ERET from decode, waits for outstanding memory traffic
// to drain (bounded by DRAIN_TIMEOUT), then for one COMMIT cycle pulses
// flush, clr_llbit and either clr_erl, clr_exl or bad_eret, and finally
// presents the return target to fetch over a valid/ready handshake.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_eret_valid            ERET request from decode
//   o_eret_ready            unit idle, ERET can be accepted
//   i_status_exl/_erl       CP0 Status.EXL / Status.ERL, sampled at accept
//   i_epc, i_error_epc      CP0 EPC / ErrorEPC, sampled at accept
//   i_mem_busy              outstanding loads/stores exist
//   o_flush, o_clr_exl, o_clr_erl, o_clr_llbit, o_bad_eret, o_drain_timeout
//                           one-cycle pulses, only during COMMIT
//   o_redirect_valid/_pc    return target to fetch
//   i_redirect_ready        fetch accepts redirect
//   o_busy                  sequencer not idle

module eret_unit #(
  parameter int DRAIN_TIMEOUT = 255,
  parameter int CNT_W         = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_eret_valid,
  output logic        o_eret_ready,
  input  logic        i_status_exl,
  input  logic        i_status_erl,
  input  logic [31:0] i_epc,
  input  logic [31:0] i_error_epc,
  input  logic        i_mem_busy,
  output logic        o_flush,
  output logic        o_clr_exl,
  output logic        o_clr_erl,
  output logic        o_clr_llbit,
  output logic        o_bad_eret,
  output logic        o_drain_timeout,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  input  logic        i_redirect_ready,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_COMMIT,
    S_REDIRECT
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_exl;
  logic               r_erl;
  logic [31:0]        r_target;
  logic               r_eret_ready;
  logic               r_busy;
  logic               r_flush;
  logic               r_clr_exl;
  logic               r_clr_erl;
  logic               r_clr_llbit;
  logic               r_bad_eret;
  logic               r_drain_timeout;
  logic               r_redirect_valid;

  // Leave DRAIN when memory is quiet or the wait budget is exhausted.
  logic w_drain_done;
  assign w_drain_done = !i_mem_busy || (r_cnt == LP_CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_exl            <= 1'b0;
      r_erl            <= 1'b0;
      r_target         <= '0;
      r_eret_ready     <= 1'b1;
      r_busy           <= 1'b0;
      r_flush          <= 1'b0;
      r_clr_exl        <= 1'b0;
      r_clr_erl        <= 1'b0;
      r_clr_llbit      <= 1'b0;
      r_bad_eret       <= 1'b0;
      r_drain_timeout  <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else begin
      // Pulse outputs are set only on the DRAIN->COMMIT edge, so they are
      // high for exactly the COMMIT cycle.
      r_flush         <= 1'b0;
      r_clr_exl       <= 1'b0;
      r_clr_erl       <= 1'b0;
      r_clr_llbit     <= 1'b0;
      r_bad_eret      <= 1'b0;
      r_drain_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_eret_valid) begin
            r_exl        <= i_status_exl;
            r_erl        <= i_status_erl;
            // ERL has priority: return through ErrorEPC.
            r_target     <= i_status_erl ? i_error_epc : i_epc;
            r_cnt        <= '0;
            r_eret_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (w_drain_done) begin
            r_flush         <= 1'b1;
            r_clr_llbit     <= 1'b1;
            r_clr_erl       <= r_erl;
            r_clr_exl       <= !r_erl && r_exl;
            r_bad_eret      <= !r_erl && !r_exl;
            // Still busy here means the budget ran out.
            r_drain_timeout <= i_mem_busy;
            r_state         <= S_COMMIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_COMMIT: begin
          r_redirect_valid <= 1'b1;
          r_state          <= S_REDIRECT;
        end

        S_REDIRECT: begin
          if (i_redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_eret_ready     <= 1'b1;
            r_busy           <= 1'b0;
            r_state          <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_eret_ready     = r_eret_ready;
  assign o_busy           = r_busy;
  assign o_flush          = r_flush;
  assign o_clr_exl        = r_clr_exl;
  assign o_clr_erl        = r_clr_erl;
  assign o_clr_llbit      = r_clr_llbit;
  assign o_bad_eret       = r_bad_eret;
  assign o_drain_timeout  = r_drain_timeout;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_target;

endmodule

// File: tb/tb_eret_unit.sv
// tb/tb_eret_unit.sv - scoreboard testbench for eret_unit

module tb_eret_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        eret_valid = 1'b0;
  logic        status_exl = 1'b0;
  logic        status_erl = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] error_epc = '0;
  logic        mem_busy = 1'b0;
  logic        redirect_ready = 1'b0;
  logic        sel_b = 1'b0;

  // Instance A: default timeout. Instance B: DRAIN_TIMEOUT=4.
  logic a_ready, a_flush, a_cexl, a_cerl, a_cll, a_bad, a_to, a_rv, a_busy;
  logic b_ready, b_flush, b_cexl, b_cerl, b_cll, b_bad, b_to, b_rv, b_busy;
  logic [31:0] a_pc, b_pc;

  eret_unit u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_eret_valid(eret_valid && !sel_b),
    .o_eret_ready(a_ready), .i_status_exl(status_exl), .i_status_erl(status_erl),
    .i_epc(epc), .i_error_epc(error_epc), .i_mem_busy(mem_busy),
    .o_flush(a_flush), .o_clr_exl(a_cexl), .o_clr_erl(a_cerl), .o_clr_llbit(a_cll),
    .o_bad_eret(a_bad), .o_drain_timeout(a_to), .o_redirect_valid(a_rv),
    .o_redirect_pc(a_pc), .i_redirect_ready(redirect_ready && !sel_b), .o_busy(a_busy)
  );

  eret_unit #(.DRAIN_TIMEOUT(4), .CNT_W(16)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_eret_valid(eret_valid && sel_b),
    .o_eret_ready(b_ready), .i_status_exl(status_exl), .i_status_erl(status_erl),
    .i_epc(epc), .i_error_epc(error_epc), .i_mem_busy(mem_busy),
    .o_flush(b_flush), .o_clr_exl(b_cexl), .o_clr_erl(b_cerl), .o_clr_llbit(b_cll),
    .o_bad_eret(b_bad), .o_drain_timeout(b_to), .o_redirect_valid(b_rv),
    .o_redirect_pc(b_pc), .i_redirect_ready(redirect_ready && sel_b), .o_busy(b_busy)
  );

  logic        m_ready, m_flush, m_rv, m_busy, m_valid, m_rr;
  logic [4:0]  m_pulses;
  logic [31:0] m_pc;
  assign m_ready  = sel_b ? b_ready : a_ready;
  assign m_flush  = sel_b ? b_flush : a_flush;
  assign m_rv     = sel_b ? b_rv : a_rv;
  assign m_busy   = sel_b ? b_busy : a_busy;
  assign m_pc     = sel_b ? b_pc : a_pc;
  assign m_valid  = eret_valid;
  assign m_rr     = redirect_ready;
  // {clr_exl, clr_erl, clr_llbit, bad_eret, drain_timeout}
  assign m_pulses = sel_b ? {b_cexl, b_cerl, b_cll, b_bad, b_to}
                          : {a_cexl, a_cerl, a_cll, a_bad, a_to};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    logic [4:0]  flags;
    logic [31:0] pc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   done = 0;
  bit   exp_redir = 0;
  bit   idle_chk = 0;
  bit   prev_rv = 0;
  bit   prev_rr = 0;
  logic [31:0] prev_pc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      exp_redir = 0;
      idle_chk  = 0;
      prev_rv   = 0;
    end else begin
      if (idle_chk) begin
        check("idle_after_redirect", {31'd0, m_ready}, 32'd1);
        idle_chk = 0;
      end
      if (m_valid && m_ready) acc_cyc = cyc;
      if (m_flush) begin
        if (q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          check("commit_flags", {27'd0, m_pulses}, {27'd0, q[0].flags});
          check("commit_latency", cyc - acc_cyc, q[0].lat);
        end
        exp_redir = 1;
      end else begin
        if (m_pulses != 5'd0) check("pulse_outside_commit", {27'd0, m_pulses}, 32'd0);
        if (exp_redir) begin
          check("redirect_after_commit", {31'd0, m_rv}, 32'd1);
          exp_redir = 0;
        end
      end
      if (m_rv) begin
        if (prev_rv && !prev_rr) check("pc_held", m_pc, prev_pc);
        if (m_rr) begin
          check("ready_during_redirect", {31'd0, m_ready}, 32'd0);
          if (q.size() == 0) begin
            check("unexpected_redirect", 32'd1, 32'd0);
          end else begin
            check("redirect_pc", m_pc, q[0].pc);
            void'(q.pop_front());
          end
          done = 1;
          idle_chk = 1;
        end
      end
      prev_rv = m_rv;
      prev_rr = m_rr;
      prev_pc = m_pc;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!m_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_ready) check("wait_ready", 32'd0, 32'd1);
  endtask

  // Issue one ERET. b = cycles mem_busy stays high, counting the accept cycle;
  // rdelay = cycles redirect_ready stays low once redirect_valid rises.
  task automatic issue(input logic exl, input logic erl, input logic [31:0] epc_v,
                       input logic [31:0] eepc_v, input int b, input int rdelay,
                       input logic use_b);
    exp_t e;
    int to, rem, n, rv_cnt;
    sel_b = use_b;
    to = use_b ? 4 : 255;
    e.flags = erl ? 5'b01100 : (exl ? 5'b10100 : 5'b00110);
    e.pc = erl ? eepc_v : epc_v;
    if (b - 1 >= to) begin
      e.lat = to + 1;
      e.flags[0] = 1'b1;
    end else begin
      e.lat = ((b < 1) ? 1 : b) + 1;
    end
    wait_ready();
    q.push_back(e);
    done = 0;
    status_exl = exl;
    status_erl = erl;
    epc = epc_v;
    error_epc = eepc_v;
    eret_valid = 1'b1;
    rem = b;
    mem_busy = (rem > 0);
    @(posedge clk); #1;
    eret_valid = 1'b0;
    // Post-accept CP0 changes must not affect the snapshot.
    epc = ~epc_v;
    error_epc = ~eepc_v;
    status_exl = ~exl;
    status_erl = ~erl;
    rem--;
    mem_busy = (rem > 0);
    n = 0;
    rv_cnt = 0;
    while (!done && n < 400) begin
      if (m_rv) begin
        redirect_ready = (rv_cnt >= rdelay);
        rv_cnt++;
      end
      @(posedge clk); #1;
      rem--;
      mem_busy = (rem > 0);
      n++;
    end
    if (!done) check("eret_complete", 32'd0, 32'd1);
    redirect_ready = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {31'd0, m_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
    check({tag, "_rv"}, {31'd0, m_rv}, 32'd0);
    check({tag, "_pulses"}, {26'd0, m_flush, m_pulses}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_quiet("reset");
    check("reset_pc", a_pc, 32'd0);

    issue(1'b1, 1'b0, 32'hBFC0_0100, 32'h0000_0000, 0, 0, 1'b0);
    issue(1'b1, 1'b1, 32'h1234_5678, 32'h8000_0040, 0, 0, 1'b0);
    issue(1'b1, 1'b0, 32'h8000_0180, 32'hDEAD_BEEF, 5, 0, 1'b0);
    issue(1'b1, 1'b0, 32'h8000_0200, 32'h0, 100, 0, 1'b1);
    sel_b = 1'b0;
    issue(1'b0, 1'b0, 32'h0040_0004, 32'hBFC0_0000, 0, 3, 1'b0);

    // Reset while draining: no commit may follow.
    wait_ready();
    status_exl = 1'b1;
    epc = 32'h1111_0000;
    eret_valid = 1'b1;
    mem_busy = 1'b1;
    @(posedge clk); #1;
    eret_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_busy = 1'b0;
    check_quiet("rst_drain");
    repeat (4) @(posedge clk);
    #1;

    // Reset while redirecting: redirect must be withdrawn.
    e.flags = 5'b10100;
    e.pc = 32'h2222_0000;
    e.lat = 2;
    q.push_back(e);
    status_exl = 1'b1;
    status_erl = 1'b0;
    epc = 32'h2222_0000;
    eret_valid = 1'b1;
    @(posedge clk); #1;
    eret_valid = 1'b0;
    n = 0;
    while (!m_rv && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_redir_reached", {31'd0, m_rv}, 32'd1);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check_quiet("rst_redir");

    for (int i = 0; i < 6; i++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
